// File: rtl/sequential_pkg.sv
// Shared types and constants for the sequential-circuits counter family.
// Pure declarations; no logic, no latency, no flow control.
package sequential_pkg;

    localparam int DEFAULT_CNT_WIDTH = 4;

    typedef enum logic {
        CNT_RUN  = 1'b0,
        CNT_DONE = 1'b1
    } cnt_state_e;

endpackage

// File: rtl/sync_down_counter.sv
// Loadable down counter with enable, auto-reload/one-shot and terminal-count borrow.
// Latency: q/borrow/done one edge after inputs; zero is combinational from q.
// Backpressure: none; en stalls the count, load overrides en.
module sync_down_counter
    import sequential_pkg::*;
#(
    parameter int               WIDTH      = DEFAULT_CNT_WIDTH,
    parameter logic [WIDTH-1:0] RELOAD_RST = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             auto_reload,
    output logic [WIDTH-1:0] q,
    output logic             zero,
    output logic             borrow,
    output logic             done
);

    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             borrow_q, borrow_d;
    cnt_state_e       state_q, state_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q      <= '0;
            reload_q <= RELOAD_RST;
            borrow_q <= 1'b0;
            state_q  <= CNT_RUN;
        end else begin
            q_q      <= q_d;
            reload_q <= reload_d;
            borrow_q <= borrow_d;
            state_q  <= state_d;
        end
    end

    always_comb begin
        q_d      = q_q;
        reload_d = reload_q;
        borrow_d = 1'b0;
        state_d  = state_q;

        if (load) begin
            q_d      = load_val;
            reload_d = load_val;
            state_d  = CNT_RUN;
        end else begin
            unique case (state_q)
                CNT_RUN: begin
                    if (en) begin
                        if (q_q == '0) begin
                            // Terminal count: the mode input matters only here.
                            borrow_d = 1'b1;
                            if (auto_reload) begin
                                q_d = reload_q;
                            end else begin
                                state_d = CNT_DONE;
                            end
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                end
                CNT_DONE: begin
                    // Expired one-shot holds at zero until reloaded.
                    q_d = q_q;
                end
                default: begin
                    state_d = CNT_RUN;
                end
            endcase
        end
    end

    assign q      = q_q;
    assign zero   = (q_q == '0);
    assign borrow = borrow_q;
    assign done   = (state_q == CNT_DONE);

endmodule

// File: doc/sync_down_counter.md
Name: sync_down_counter

Overview:
Synchronous, loadable binary down counter with enable, auto-reload or one-shot mode, and a terminal-count borrow pulse. It is the count-down counterpart to the team's up counters. Typical uses are timeouts, prescalers and delay generators in the sequential-circuits library.
- All flops run on one clock.
- No ripple clocking.

Parameters:
WIDTH, 4, counter width in bits.
RELOAD_RST, {WIDTH{1'b1}}, reset value of the internal reload register.

Ports:
clk  input  1  rising-edge clock for all state.
reset_n  input  1  asynchronous, active-low reset.
en  input  1  count enable; decrement only when high.
load  input  1  parallel load strobe.
load_val  input  WIDTH  value loaded into q and into the reload register on load.
auto_reload  input  1  1 = wrap from 0 to the reload value; 0 = one-shot, stop at 0.
q  output  WIDTH  current count, registered.
zero  output  1  combinational (q == 0).
borrow  output  1  registered one-cycle pulse on a terminal-count event.
done  output  1  high while the one-shot has expired (state DONE).

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (reset_n).
- Reset values while reset_n = 0:
  - q = 0
  - reload_reg = RELOAD_RST
  - borrow = 0
  - state = RUN
  - done = 0
  - zero = 1
- States:
  - RUN: counting allowed.
  - DONE: one-shot expired.
- Priority, highest first: reset_n, load, en.
- Load (any state):
  - q <= load_val, reload_reg <= load_val, state <= RUN, borrow <= 0.
  - Any en in the same cycle is ignored.
- RUN, en = 1, q != 0: q <= q - 1, borrow <= 0.
- RUN, en = 1, q == 0 (terminal-count event):
  - borrow <= 1 for exactly one cycle.
  - auto_reload = 1: q <= reload_reg, stay in RUN.
  - auto_reload = 0: q holds 0, state <= DONE.
- RUN, en = 0: q holds, borrow <= 0.
- DONE:
  - en is ignored, q holds 0, borrow <= 0, done = 1.
  - Exit only via load or reset. Raising auto_reload while in DONE does not restart the counter.
- Period: with reload value R in auto-reload mode, borrow fires once every R+1 enabled cycles.
- Out of reset with free-running en and auto_reload = 1, q runs 0, 15, 14, ..., 0 for WIDTH = 4; the first borrow occurs on the first enabled edge.
- reload_reg = 0 in auto-reload mode: q stays 0 and borrow is high on every enabled cycle.
- load_val = 0 then en: a terminal-count event on the first enabled edge.
- The mode input auto_reload is sampled only at the terminal-count event. Changing it mid-count has no other effect.
- Arithmetic: unsigned, modulo 2^WIDTH. The only wrap path is the reload path; no underflow occurs through q - 1.
- Asserting reset_n low mid-count clears everything immediately without waiting for a clock edge. Counting resumes on the first rising clk edge after release.
- Latency:
  - q, borrow and done change one clock edge after the qualifying inputs are sampled.
  - zero follows q combinationally.

Decomposition:
- Shared package sequential_pkg:
  - typedef enum for the counter state {CNT_RUN, CNT_DONE}, 1 bit.
  - DEFAULT_CNT_WIDTH = 4 constant, reused by the up counters.
- No sub-module needed. Counter datapath and 2-state FSM live in one module.
- Estimated size: about 150 lines including the reload register.

Test Plan:
1. Reset with reset_n low mid-count at q = 9 (asserted asynchronously between edges) -> q = 0, zero = 1, borrow = 0, done = 0 immediately, before the next clk edge.
2. Free run from reset, en = 1, auto_reload = 1, WIDTH = 4 -> q sequence 0, 15, 14, ..., 1, 0, 15. borrow pulses one cycle on each 0 -> 15 transition, every 16 cycles.
3. load_val = 5, one cycle of load, then en = 1, auto_reload = 0 -> q = 5, 4, 3, 2, 1, 0, then one borrow pulse, done = 1. Further en leaves q = 0 and borrow = 0. A new load of 3 clears done and counts 3, 2, 1, 0.
4. load = 1 and en = 1 in the same cycle with load_val = 7 while q = 2 -> q = 7 next cycle, no decrement, no borrow.
5. en toggled 1, 0, 0, 1 from q = 4 -> q = 3, 3, 3, 2. borrow stays 0.
6. Load 0 with auto_reload = 1, then en held high for 3 cycles -> q stays 0, borrow high on all 3 cycles, zero = 1 throughout.
